vend_ctrl: RTL and testbench
============================

// Module: vend_ctrl
// PURPOSE
//  Sequencing FSM for the vending-machine datapath (coin accumulation, cost, dispense, change).
//  Drives every LD_*/CD_*/Sel_* strobe; consumes Z, Z2, exceed, ready, A. Sits beside dataPath in top.
//  Its DP_RST output is ORed with RST at top to clear the datapath after each transaction.
// PARAMETERS
//  TIMEOUT_CYC  1000  idle cycles with credit before auto-refund (used only with VEND_TIMEOUT_EN)
//  TO_W         10    timeout counter width; TIMEOUT_CYC must be < 2**TO_W
// PORTS
//  CLK          in   1  clock; only clock in block
//  RST          in   1  synchronous, active-high reset
//  coin_valid   in   1  one-cycle coin strobe
//  coin_type    in   2  00=1, 01=2, 10=10, 11=20 (passed to Sel_ADD_IN)
//  order        in   1  one-cycle order strobe; Kind/Cups stable at top
//  cancel       in   1  one-cycle refund request
//  price_ld     in   1  one-cycle price-update request
//  Z, Z2        in   1  CNT==0, D==0
//  exceed       in   1  A>20
//  ready        in   1  enough credit, valid kind, cups>0
//  A            in   7  credit register value
//  LD_A,LD_B,LD_C,LD_D,LD_E,LD_CNT,LD_MEM,CD_D,CD_CNT  out 1 each  datapath strobes
//  Sel_DIV_IN   out  1  1=A, 0=B into divider
//  Sel_A_IN     out  2  00=sum, 10=const 20, 11=remain_money
//  Sel_ADD_IN   out  2  coin selector
//  Sel_DIVISOR  out  2  00=1, 10=10
//  DP_RST       out  1  datapath clear pulse
//  dispense     out  1  one pulse per cup
//  chg10, chg1  out  1  one pulse per 10- / 1-unit coin returned
//  overflow     out  1  pulse: credit clamped to 20
//  no_money     out  1  pulse: order rejected
//  busy         out  1  state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; every output 0. Outputs are Moore/Mealy decode, default 0 in every state.
//  IDLE priority when strobes coincide: price_ld > coin_valid > cancel > order.
//   price_ld: LD_MEM=1 this cycle, stay IDLE.
//   coin_valid: Sel_ADD_IN=coin_type, Sel_A_IN=00, LD_A=1 -> COIN_CHK.
//   cancel: -> CHG_LD.
//   order: LD_C=1, LD_D=1 -> COST.
//  COIN_CHK: if exceed: Sel_A_IN=10, LD_A=1, overflow=1 (excess forfeited). -> IDLE.
//  COST: LD_E=1 -> CHECK.
//  CHECK: ready ? (Sel_A_IN=11, LD_A=1 -> DISP) : (no_money=1 -> IDLE; credit kept).
//  DISP: Z2 ? -> CHG_LD : (CD_D=1, dispense=1, stay). N cups = N dispense pulses, consecutive.
//  CHG_LD: Sel_DIV_IN=1, Sel_DIVISOR=10, LD_CNT=1, LD_B=1 -> CHG_TEN.
//  CHG_TEN: Z ? -> CHG_LD1 : (CD_CNT=1, chg10=1).
//  CHG_LD1: Sel_DIV_IN=0, Sel_DIVISOR=00, LD_CNT=1 -> CHG_ONE.
//  CHG_ONE: Z ? -> DONE : (CD_CNT=1, chg1=1).
//  DONE: DP_RST=1 -> IDLE. MEM prices survive (not reset).
//  Z sampled only in the cycle after LD_CNT or later (CNT has no reset).
//  Strobes outside IDLE are ignored (not queued). Cancel with A=0: zero change pulses, DONE, IDLE.
//  RST mid-transaction: next cycle IDLE, outputs 0; pulses already issued are not undone.
//  Latency order->first dispense: 3 cycles (COST, CHECK, DISP).
// CONFIGURATION
//  VEND_TIMEOUT_EN defined: TO_W counter counts in IDLE while A!=0; cleared on any
//   coin_valid/order/price_ld or leaving IDLE; at TIMEOUT_CYC-1 acts as cancel (-> CHG_LD).
//  Undefined: no counter; credit held indefinitely, refund only via cancel.
// TESTING
//  price_ld with price 3; coins 10,2; order kind=01 cups=2 -> 2 dispense, 0 chg10, 6 chg1, DP_RST, IDLE.
//  Coins 20 then 2 -> overflow pulse one cycle after second LD_A; A==20.
//  Coin 1; order kind=01 cups=1 with price 3 -> no_money pulse, IDLE, A==1.
//  Coins 10,10,2 (clamped to 20) then cancel -> 2 chg10, 0 chg1, DP_RST.
//  coin_valid and cancel same IDLE cycle -> coin taken, cancel dropped; RST during DISP -> IDLE, outputs 0.
//  VEND_TIMEOUT_EN, TIMEOUT_CYC=8: coin 2, idle -> refund starts 8 cycles later: 2 chg1.

Source files
------------

// File: rtl/vend_ctrl.sv
// Sequencing FSM for the vending-machine datapath: coin intake, cost check, dispense, change return.
// Optional idle-credit auto-refund is compiled in when VEND_TIMEOUT_EN is defined.
module vend_ctrl #(
    parameter int TIMEOUT_CYC = 1000,
    parameter int TO_W        = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       order,
    input  logic       cancel,
    input  logic       price_ld,
    input  logic       Z,
    input  logic       Z2,
    input  logic       exceed,
    input  logic       ready,
    input  logic [6:0] A,
    output logic       LD_A,
    output logic       LD_B,
    output logic       LD_C,
    output logic       LD_D,
    output logic       LD_E,
    output logic       LD_CNT,
    output logic       LD_MEM,
    output logic       CD_D,
    output logic       CD_CNT,
    output logic       Sel_DIV_IN,
    output logic [1:0] Sel_A_IN,
    output logic [1:0] Sel_ADD_IN,
    output logic [1:0] Sel_DIVISOR,
    output logic       DP_RST,
    output logic       dispense,
    output logic       chg10,
    output logic       chg1,
    output logic       overflow,
    output logic       no_money,
    output logic       busy
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] COIN_CHK = 4'd1;
    localparam logic [3:0] COST     = 4'd2;
    localparam logic [3:0] CHECK    = 4'd3;
    localparam logic [3:0] DISP     = 4'd4;
    localparam logic [3:0] CHG_LD   = 4'd5;
    localparam logic [3:0] CHG_TEN  = 4'd6;
    localparam logic [3:0] CHG_LD1  = 4'd7;
    localparam logic [3:0] CHG_ONE  = 4'd8;
    localparam logic [3:0] DONE     = 4'd9;

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic       timeout_hit;

`ifdef VEND_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            to_run;

    // Counter only advances while credit sits untouched in IDLE
    assign to_run      = (state == IDLE) && (A != 7'd0) && !coin_valid && !order && !price_ld;
    assign timeout_hit = to_run && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            to_cnt <= '0;
        end else if (to_run && !timeout_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end
`else
    logic unused_cfg;

    assign timeout_hit = 1'b0;
    assign unused_cfg  = ^{A, TO_W'(TIMEOUT_CYC)};
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs are held low for the whole reset cycle so no strobe leaks to the datapath
    always_comb begin
        state_nxt   = state;
        LD_A        = 1'b0;
        LD_B        = 1'b0;
        LD_C        = 1'b0;
        LD_D        = 1'b0;
        LD_E        = 1'b0;
        LD_CNT      = 1'b0;
        LD_MEM      = 1'b0;
        CD_D        = 1'b0;
        CD_CNT      = 1'b0;
        Sel_DIV_IN  = 1'b0;
        Sel_A_IN    = 2'b00;
        Sel_ADD_IN  = 2'b00;
        Sel_DIVISOR = 2'b00;
        DP_RST      = 1'b0;
        dispense    = 1'b0;
        chg10       = 1'b0;
        chg1        = 1'b0;
        overflow    = 1'b0;
        no_money    = 1'b0;
        busy        = 1'b0;
        if (!RST) begin
            busy = (state != IDLE);
            case (state)
                IDLE: begin
                    if (price_ld) begin
                        LD_MEM = 1'b1;
                    end else if (coin_valid) begin
                        Sel_ADD_IN = coin_type;
                        Sel_A_IN   = 2'b00;
                        LD_A       = 1'b1;
                        state_nxt  = COIN_CHK;
                    end else if (cancel || timeout_hit) begin
                        state_nxt = CHG_LD;
                    end else if (order) begin
                        LD_C      = 1'b1;
                        LD_D      = 1'b1;
                        state_nxt = COST;
                    end
                end
                COIN_CHK: begin
                    // Credit above 20 is clamped; the excess is forfeited
                    if (exceed) begin
                        Sel_A_IN = 2'b10;
                        LD_A     = 1'b1;
                        overflow = 1'b1;
                    end
                    state_nxt = IDLE;
                end
                COST: begin
                    LD_E      = 1'b1;
                    state_nxt = CHECK;
                end
                CHECK: begin
                    if (ready) begin
                        Sel_A_IN  = 2'b11;
                        LD_A      = 1'b1;
                        state_nxt = DISP;
                    end else begin
                        no_money  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                DISP: begin
                    if (Z2) begin
                        state_nxt = CHG_LD;
                    end else begin
                        CD_D     = 1'b1;
                        dispense = 1'b1;
                    end
                end
                CHG_LD: begin
                    Sel_DIV_IN  = 1'b1;
                    Sel_DIVISOR = 2'b10;
                    LD_CNT      = 1'b1;
                    LD_B        = 1'b1;
                    state_nxt   = CHG_TEN;
                end
                CHG_TEN: begin
                    if (Z) begin
                        state_nxt = CHG_LD1;
                    end else begin
                        CD_CNT = 1'b1;
                        chg10  = 1'b1;
                    end
                end
                CHG_LD1: begin
                    Sel_DIV_IN  = 1'b0;
                    Sel_DIVISOR = 2'b00;
                    LD_CNT      = 1'b1;
                    state_nxt   = CHG_ONE;
                end
                CHG_ONE: begin
                    if (Z) begin
                        state_nxt = DONE;
                    end else begin
                        CD_CNT = 1'b1;
                        chg1   = 1'b1;
                    end
                end
                DONE: begin
                    DP_RST    = 1'b1;
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl with a small behavioural datapath model closing the loop.
// Define VEND_TIMEOUT_EN for both files to also exercise the idle auto-refund.
module tb_vend_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = 2'b00;
    logic       order = 1'b0;
    logic       cancel = 1'b0;
    logic       price_ld = 1'b0;
    logic       Z, Z2, exceed, ready;
    logic [6:0] A;
    logic       LD_A, LD_B, LD_C, LD_D, LD_E, LD_CNT, LD_MEM, CD_D, CD_CNT;
    logic       Sel_DIV_IN;
    logic [1:0] Sel_A_IN, Sel_ADD_IN, Sel_DIVISOR;
    logic       DP_RST, dispense, chg10, chg1, overflow, no_money, busy;

    logic [1:0] kind_in = 2'd1;
    logic [3:0] cups_in = 4'd0;
    logic [6:0] price_in = 7'd0;

    int passCount = 0;
    int totalCount = 0;
    int nDisp = 0, nChg10 = 0, nChg1 = 0, nDpRst = 0;
    int sDisp, sChg10, sChg1, sDpRst;

    logic [22:0] outs;
    assign outs = {LD_A, LD_B, LD_C, LD_D, LD_E, LD_CNT, LD_MEM, CD_D, CD_CNT, Sel_DIV_IN,
                   Sel_A_IN, Sel_ADD_IN, Sel_DIVISOR, DP_RST, dispense, chg10, chg1,
                   overflow, no_money, busy};

    always #5 CLK = ~CLK;

    vend_ctrl #(.TIMEOUT_CYC(8), .TO_W(10)) dut (
        .CLK(CLK), .RST(RST), .coin_valid(coin_valid), .coin_type(coin_type),
        .order(order), .cancel(cancel), .price_ld(price_ld), .Z(Z), .Z2(Z2),
        .exceed(exceed), .ready(ready), .A(A), .LD_A(LD_A), .LD_B(LD_B), .LD_C(LD_C),
        .LD_D(LD_D), .LD_E(LD_E), .LD_CNT(LD_CNT), .LD_MEM(LD_MEM), .CD_D(CD_D),
        .CD_CNT(CD_CNT), .Sel_DIV_IN(Sel_DIV_IN), .Sel_A_IN(Sel_A_IN),
        .Sel_ADD_IN(Sel_ADD_IN), .Sel_DIVISOR(Sel_DIVISOR), .DP_RST(DP_RST),
        .dispense(dispense), .chg10(chg10), .chg1(chg1), .overflow(overflow),
        .no_money(no_money), .busy(busy)
    );

    // Datapath model: credit A, remainder B, kind C, cups D, cost E, change counter CNT, price MEM
    logic [6:0] a_r = '0, b_r = '0, cnt_r = '0;
    logic [1:0] c_r = '0;
    logic [3:0] d_r = '0;
    logic [7:0] e_r = '0;
    logic [6:0] mem_r [0:3];
    logic [6:0] coin_val, div_src, divisor;

    always_comb begin
        case (Sel_ADD_IN)
            2'b00:   coin_val = 7'd1;
            2'b01:   coin_val = 7'd2;
            2'b10:   coin_val = 7'd10;
            default: coin_val = 7'd20;
        endcase
        div_src = Sel_DIV_IN ? a_r : b_r;
        divisor = (Sel_DIVISOR == 2'b10) ? 7'd10 : 7'd1;
    end

    assign A      = a_r;
    assign Z      = (cnt_r == 7'd0);
    assign Z2     = (d_r == 4'd0);
    assign exceed = (a_r > 7'd20);
    assign ready  = ({1'b0, a_r} >= e_r) && (c_r != 2'd0) && (d_r != 4'd0);

    always @(posedge CLK) begin
        if (LD_MEM) mem_r[kind_in] <= price_in;
        if (LD_CNT) cnt_r <= div_src / divisor;
        else if (CD_CNT) cnt_r <= cnt_r - 7'd1;
        if (RST || DP_RST) begin
            a_r <= '0; b_r <= '0; c_r <= '0; d_r <= '0; e_r <= '0;
        end else begin
            if (LD_A) begin
                case (Sel_A_IN)
                    2'b00:   a_r <= a_r + coin_val;
                    2'b10:   a_r <= 7'd20;
                    default: a_r <= a_r - e_r[6:0];
                endcase
            end
            if (LD_B) b_r <= div_src % divisor;
            if (LD_C) c_r <= kind_in;
            if (LD_D) d_r <= cups_in;
            else if (CD_D) d_r <= d_r - 4'd1;
            if (LD_E) e_r <= 8'(mem_r[c_r] * {3'b000, d_r});
        end
    end

    always @(posedge CLK) begin
        if (dispense) nDisp <= nDisp + 1;
        if (chg10)    nChg10 <= nChg10 + 1;
        if (chg1)     nChg1 <= nChg1 + 1;
        if (DP_RST)   nDpRst <= nDpRst + 1;
    end

    task automatic applyStimulus(input logic cv, input logic [1:0] ct, input logic ord,
                                 input logic canc, input logic pld);
        @(negedge CLK);
        coin_valid = cv;
        coin_type  = ct;
        order      = ord;
        cancel     = canc;
        price_ld   = pld;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCount++;
        assert (got === exp) passCount++;
        else begin
            $display("[TB] FAIL %s: observed %0d required %0d", tag, got, exp);
            $error("[TB] %s observed %0d required %0d", tag, got, exp);
        end
    endtask

    task automatic snapshot();
        sDisp = nDisp; sChg10 = nChg10; sChg1 = nChg1; sDpRst = nDpRst;
    endtask

    task automatic waitIdle(input int maxCyc);
        int n = 0;
        idleCycle();
        while (busy && n < maxCyc) begin
            idleCycle();
            n++;
        end
        checkOutput("wait_idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic checkChange(input string tag, input int d, input int c10, input int c1, input int dr);
        checkOutput({tag, "_dispense"}, 32'(nDisp - sDisp), 32'(d));
        checkOutput({tag, "_chg10"}, 32'(nChg10 - sChg10), 32'(c10));
        checkOutput({tag, "_chg1"}, 32'(nChg1 - sChg1), 32'(c1));
        checkOutput({tag, "_dp_rst"}, 32'(nDpRst - sDpRst), 32'(dr));
    endtask

    initial begin
        idleCycle();
        checkOutput("reset_outputs", 32'(outs), 32'd0);
        idleCycle();
        RST = 1'b0;
        idleCycle();
        checkOutput("post_reset_outputs", 32'(outs), 32'd0);

        // Full purchase: price 3, credit 12, two cups -> 6 units back
        kind_in = 2'd1; price_in = 7'd3; cups_in = 4'd2;
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("price_ld_LD_MEM", 32'(LD_MEM), 32'd1);
        checkOutput("price_ld_busy", 32'(busy), 32'd0);
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        checkOutput("coin10_ctrl", 32'({LD_A, Sel_ADD_IN, Sel_A_IN}), 32'b11000);
        idleCycle();
        checkOutput("coin_chk_busy", 32'(busy), 32'd1);
        checkOutput("coin_chk_no_overflow", 32'(overflow), 32'd0);
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        idleCycle();
        idleCycle();
        checkOutput("credit_12", 32'(a_r), 32'd12);
        snapshot();
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        checkOutput("order_LD_C_D", 32'({LD_C, LD_D}), 32'b11);
        idleCycle();
        checkOutput("cost_LD_E", 32'(LD_E), 32'd1);
        idleCycle();
        checkOutput("check_load_remain", 32'({LD_A, Sel_A_IN}), 32'b111);
        idleCycle();
        checkOutput("first_dispense_latency", 32'(dispense), 32'd1);
        waitIdle(40);
        checkChange("purchase", 2, 0, 6, 1);
        checkOutput("purchase_credit_cleared", 32'(a_r), 32'd0);

        // Coins 20 then 2: overflow in the cycle after the second LD_A
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        idleCycle();
        checkOutput("no_overflow_at_20", 32'(overflow), 32'd0);
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        checkOutput("second_coin_LD_A", 32'(LD_A), 32'd1);
        idleCycle();
        checkOutput("overflow_ctrl", 32'({overflow, LD_A, Sel_A_IN}), 32'b1110);
        idleCycle();
        checkOutput("clamped_credit", 32'(a_r), 32'd20);
        snapshot();
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        waitIdle(40);
        checkChange("cancel20", 0, 2, 0, 1);

        // Insufficient credit: order rejected, credit kept
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        idleCycle();
        cups_in = 4'd1;
        snapshot();
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        idleCycle();
        idleCycle();
        checkOutput("no_money_pulse", 32'({no_money, LD_A}), 32'b10);
        idleCycle();
        checkOutput("no_money_back_idle", 32'(busy), 32'd0);
        checkOutput("no_money_credit_kept", 32'(a_r), 32'd1);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        waitIdle(40);
        checkChange("cancel1", 0, 0, 1, 1);

        // Cancel with zero credit still passes through DONE
        snapshot();
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        waitIdle(40);
        checkChange("cancel0", 0, 0, 0, 1);

        // Coins 10,10,2 clamp to 20, then refund
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        idleCycle();
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        idleCycle();
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        idleCycle();
        checkOutput("clamp22_overflow", 32'(overflow), 32'd1);
        snapshot();
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        waitIdle(40);
        checkChange("cancel22", 0, 2, 0, 1);

        // Strobe priority in IDLE
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        checkOutput("price_over_coin", 32'({LD_MEM, LD_A}), 32'b10);
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b1, 1'b0);
        checkOutput("coin_over_cancel", 32'(LD_A), 32'd1);
        idleCycle();
        checkOutput("cancel_dropped", 32'({busy, LD_B}), 32'b10);
        idleCycle();
        checkOutput("coin_only_credit", 32'(a_r), 32'd10);

        // Reset in the middle of dispensing
        cups_in = 4'd3;
        snapshot();
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        idleCycle();
        idleCycle();
        idleCycle();
        checkOutput("disp3_first_pulse", 32'(dispense), 32'd1);
        idleCycle();
        RST = 1'b1;
        #1;
        checkOutput("rst_in_disp_outputs", 32'(outs), 32'd0);
        idleCycle();
        RST = 1'b0;
        #1;
        checkOutput("after_rst_outputs", 32'(outs), 32'd0);
        idleCycle();
        checkOutput("after_rst_idle", 32'(outs), 32'd0);
        checkOutput("rst_pulses_kept", 32'(nDisp - sDisp), 32'd1);

`ifdef VEND_TIMEOUT_EN
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        idleCycle();
        snapshot();
        for (int i = 0; i < 8; i++) idleCycle();
        checkOutput("timeout_not_yet", 32'(busy), 32'd0);
        idleCycle();
        checkOutput("timeout_refund_start", 32'({busy, LD_B}), 32'b11);
        waitIdle(40);
        checkChange("timeout", 0, 0, 2, 1);
`endif

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
